// File: rtl/pwm_multichan.sv
// -----------------------------------------------------------------------------
// pwm_multichan
//
// Register-mapped multi-channel PWM core. A byte-wide register port programs a
// shared prescaler and period, plus per-channel duty, enable and polarity.
// Period and duty writes land in shadow registers. The active copies reload
// from the shadows at a period boundary, unless LOCK is set. While EN=0 the
// active copies follow the shadows on every cycle.
//
// Optional feature macro: PWM_CENTER_ALIGN_EN
//   When defined, CTRL.b1 (CENTER) is stored and selects up/down counting.
//   When undefined, CTRL.b1 reads 0 and the up/down logic is absent.
//
// Register map:
//   0x00 CTRL   b0 EN, b1 CENTER, b2 LOCK
//   0x01 PRESC
//   0x02 PERIOD_L
//   0x03 PERIOD_H
//   0x04 CHEN
//   0x05 POL
//   0x10+2n DUTY_L(n), 0x11+2n DUTY_H(n)
//
// Ports:
//   clk         core clock
//   rst         asynchronous, active-high reset
//   regWe       register write strobe, one cycle per byte
//   regAddr     register address, used for both write and read
//   regWdata    write data
//   regRdata    registered readback of the previous cycle's regAddr
//   pwm         registered PWM outputs, one bit per channel
//   periodTick  one-cycle pulse, aligned with each active-register reload
// -----------------------------------------------------------------------------
module pwm_multichan #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWe,
  input  logic [7:0]        regAddr,
  input  logic [7:0]        regWdata,
  output logic [7:0]        regRdata,
  output logic [NUM_CH-1:0] pwm,
  output logic              periodTick
);

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_PRESC = 8'h01;
  localparam logic [7:0] ADDR_PER_L = 8'h02;
  localparam logic [7:0] ADDR_PER_H = 8'h03;
  localparam logic [7:0] ADDR_CHEN  = 8'h04;
  localparam logic [7:0] ADDR_POL   = 8'h05;

  logic                en_q, en_d;
  logic                lock_q, lock_d;
`ifdef PWM_CENTER_ALIGN_EN
  logic                center_q, center_d;
  logic                dir_q, dir_d;      // 0 = counting up, 1 = counting down
`endif
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    period_sh_q, period_sh_d;
  logic [CNT_W-1:0]    period_act_q, period_act_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   chen_q, chen_d;
  logic [NUM_CH-1:0]   pol_q, pol_d;
  logic [NUM_CH-1:0]   pwm_q, pwm_d;
  logic [CNT_W-1:0]    duty_sh_q [NUM_CH];
  logic [CNT_W-1:0]    duty_sh_d [NUM_CH];
  logic [CNT_W-1:0]    duty_act_q [NUM_CH];
  logic [CNT_W-1:0]    duty_act_d [NUM_CH];
  logic                period_tick_q, period_tick_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                tick;
  logic                boundary;

  // Counter-width values are handled as a 16-bit image, so that the two byte
  // lanes can be addressed uniformly. Bits above CNT_W are dropped on write
  // and read back as zero.
  function automatic logic [15:0] cnt_ext16(input logic [CNT_W-1:0] v);
    logic [15:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] put_byte(input logic [CNT_W-1:0] cur,
                                                input logic hi,
                                                input logic [7:0] b);
    logic [15:0] r;
    r = cnt_ext16(cur);
    if (hi) r[15:8] = b;
    else    r[7:0]  = b;
    return r[CNT_W-1:0];
  endfunction

  function automatic logic [7:0] get_byte(input logic [CNT_W-1:0] v, input logic hi);
    logic [15:0] r;
    r = cnt_ext16(v);
    return hi ? r[15:8] : r[7:0];
  endfunction

  function automatic logic [7:0] ch_byte(input logic [NUM_CH-1:0] v);
    logic [7:0] r;
    r = '0;
    r[NUM_CH-1:0] = v;
    return r;
  endfunction

  function automatic logic [7:0] presc_byte(input logic [PRESC_W-1:0] v);
    logic [7:0] r;
    r = '0;
    r[PRESC_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [7:0] duty_addr(input int n, input logic hi);
    logic [7:0] a;
    a = 8'h10 + 8'(2 * n) + {7'b0, hi};
    return a;
  endfunction

  always_comb begin
    // Register writes
    en_d        = en_q;
    lock_d      = lock_q;
`ifdef PWM_CENTER_ALIGN_EN
    center_d    = center_q;
`endif
    presc_d     = presc_q;
    period_sh_d = period_sh_q;
    chen_d      = chen_q;
    pol_d       = pol_q;
    duty_sh_d   = duty_sh_q;
    if (regWe) begin
      case (regAddr)
        ADDR_CTRL: begin
          en_d   = regWdata[0];
          lock_d = regWdata[2];
`ifdef PWM_CENTER_ALIGN_EN
          center_d = regWdata[1];
`endif
        end
        ADDR_PRESC: presc_d     = regWdata[PRESC_W-1:0];
        ADDR_PER_L: period_sh_d = put_byte(period_sh_q, 1'b0, regWdata);
        ADDR_PER_H: period_sh_d = put_byte(period_sh_q, 1'b1, regWdata);
        ADDR_CHEN:  chen_d      = regWdata[NUM_CH-1:0];
        ADDR_POL:   pol_d       = regWdata[NUM_CH-1:0];
        default: ;
      endcase
      for (int n = 0; n < NUM_CH; n++) begin
        if (regAddr == duty_addr(n, 1'b0)) duty_sh_d[n] = put_byte(duty_sh_q[n], 1'b0, regWdata);
        if (regAddr == duty_addr(n, 1'b1)) duty_sh_d[n] = put_byte(duty_sh_q[n], 1'b1, regWdata);
      end
    end

    // Prescaler and period counter; both sit at zero while disabled
    tick     = 1'b0;
    boundary = 1'b0;
    pcnt_d   = '0;
    cnt_d    = '0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d    = 1'b0;
`endif
    if (en_q) begin
      pcnt_d = pcnt_q + 1'b1;
      cnt_d  = cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d  = dir_q;
`endif
      if (pcnt_q == presc_q) begin
        tick   = 1'b1;
        pcnt_d = '0;
      end
      if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
        // Centre mode turns around at PERIOD and closes the period at zero on
        // the way down. The next period starts at 1, so the zero is not
        // repeated. PERIOD=0 falls through to the edge-mode rule.
        if (center_q && (period_act_q != '0)) begin
          if (!dir_q) begin
            if (cnt_q >= period_act_q) begin
              dir_d = 1'b1;
              cnt_d = cnt_q - 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (cnt_q == '0) begin
            boundary = 1'b1;
            dir_d    = 1'b0;
            cnt_d    = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          dir_d = 1'b0;
          if (cnt_q >= period_act_q) begin
            boundary = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`else
        if (cnt_q >= period_act_q) begin
          boundary = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
    end

    // Active registers reload from the pre-write shadow values, so a write in
    // the same cycle as a boundary takes effect at the following boundary.
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    if (!en_q || (boundary && !lock_q)) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end
    period_tick_d = boundary;

    // Outputs are idle at the polarity level while a channel is inactive
    for (int n = 0; n < NUM_CH; n++) begin
      pwm_d[n] = (en_q & chen_q[n] & (cnt_q < duty_act_q[n])) ^ pol_q[n];
    end

    // Readback reflects the stored bits only
    rdata_d = 8'h00;
    case (regAddr)
      ADDR_CTRL: begin
        rdata_d[0] = en_q;
        rdata_d[2] = lock_q;
`ifdef PWM_CENTER_ALIGN_EN
        rdata_d[1] = center_q;
`endif
      end
      ADDR_PRESC: rdata_d = presc_byte(presc_q);
      ADDR_PER_L: rdata_d = get_byte(period_sh_q, 1'b0);
      ADDR_PER_H: rdata_d = get_byte(period_sh_q, 1'b1);
      ADDR_CHEN:  rdata_d = ch_byte(chen_q);
      ADDR_POL:   rdata_d = ch_byte(pol_q);
      default: ;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      if (regAddr == duty_addr(n, 1'b0)) rdata_d = get_byte(duty_sh_q[n], 1'b0);
      if (regAddr == duty_addr(n, 1'b1)) rdata_d = get_byte(duty_sh_q[n], 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q          <= 1'b0;
      lock_q        <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      center_q      <= 1'b0;
      dir_q         <= 1'b0;
`endif
      presc_q       <= '0;
      pcnt_q        <= '0;
      period_sh_q   <= '0;
      period_act_q  <= '0;
      cnt_q         <= '0;
      chen_q        <= '0;
      pol_q         <= '0;
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
      rdata_q       <= 8'h00;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh_q[n]  <= '0;
        duty_act_q[n] <= '0;
      end
    end else begin
      en_q          <= en_d;
      lock_q        <= lock_d;
`ifdef PWM_CENTER_ALIGN_EN
      center_q      <= center_d;
      dir_q         <= dir_d;
`endif
      presc_q       <= presc_d;
      pcnt_q        <= pcnt_d;
      period_sh_q   <= period_sh_d;
      period_act_q  <= period_act_d;
      cnt_q         <= cnt_d;
      chen_q        <= chen_d;
      pol_q         <= pol_d;
      pwm_q         <= pwm_d;
      period_tick_q <= period_tick_d;
      rdata_q       <= rdata_d;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh_q[n]  <= duty_sh_d[n];
        duty_act_q[n] <= duty_act_d[n];
      end
    end
  end

  assign regRdata   = rdata_q;
  assign pwm        = pwm_q;
  assign periodTick = period_tick_q;

endmodule
